// File: rtl/ysyx_23060201_defs.sv
// Shared definitions for the writeback unit.
//   - Load funct3 encodings understood by the load extractor.
//   - WBU state encoding (kept as plain localparams so the encoding is
//     fixed and readable in legacy tooling and waveform viewers).
//   - Memory read response code for a successful read.
package ysyx_23060201_defs;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // WBU state encoding
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  // Memory read response
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060201_load_ext.sv
// Load data extractor (purely combinational).
// Selects the addressed byte/halfword/word out of an aligned read word and
// applies sign or zero extension according to the load funct3.
// Ports:
//   rdata    in  aligned read word from memory
//   fmt      in  load funct3 (LB/LH/LW/LBU/LHU)
//   addr_lo  in  low two bits of the effective address
//   data     out extracted and extended load value
//   misalign out address not naturally aligned for the access size
//   bad_fmt  out funct3 is not a supported load encoding
module ysyx_23060201_load_ext
  import ysyx_23060201_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            fmt,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misalign,
  output logic                  bad_fmt
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane k lives at rdata[8k+7:8k]; halfwords only use lanes 0 and 2.
  assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a value unassigned, which would infer a latch.
    data     = '0;
    misalign = 1'b0;
    bad_fmt  = 1'b0;
    case (fmt)
      LB:  data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      LBU: data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      LH: begin
        data     = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        misalign = addr_lo[0];
      end
      LHU: begin
        data     = {{(DATA_WIDTH-16){1'b0}}, w_half};
        misalign = addr_lo[0];
      end
      LW: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
      default: bad_fmt = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_wbu.sv
// Writeback unit, sitting directly in front of the GPR file.
// Takes one retiring instruction per handshake, waits for the read
// response on loads, then spends exactly one WRITE cycle driving the GPR
// write port and a commit pulse for the IFU.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream packet handshake
//   in_rd, in_rd_wen          destination register and its write enable
//   in_is_load, in_load_fmt,
//   in_addr_lo                load control (funct3, low address bits)
//   in_result, in_pc          non-load result and instruction PC
//   mem_rvalid / mem_rready   read data handshake
//   mem_rdata, mem_rresp      aligned read word and response code
//   gpr_wen/waddr/wdata       GPR write port (one cycle per instruction)
//   wb_valid, wb_pc, wb_err   commit pulse, its PC and load-fault flag
module ysyx_23060201_wbu
  import ysyx_23060201_defs::*;
#(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rd_wen,
  input  logic                      in_is_load,
  input  logic [2:0]                in_load_fmt,
  input  logic [1:0]                in_addr_lo,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic                      mem_rvalid,
  output logic                      mem_rready,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic [1:0]                mem_rresp,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      wb_valid,
  output logic [DATA_WIDTH-1:0]     wb_pc,
  output logic                      wb_err
);

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic [GPR_ADDR_WIDTH-1:0] r_rd;
  logic                      r_rd_wen;
  logic [2:0]                r_fmt;
  logic [1:0]                r_addr_lo;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic                      r_err;

  logic                      w_accept;
  logic                      w_mem_fire;
  logic                      w_in_write;
  logic [DATA_WIDTH-1:0]     w_ext_data;
  logic                      w_misalign;
  logic                      w_bad_fmt;

  // A new packet may enter while idle or during the WRITE cycle, which is
  // what lets back-to-back non-loads commit every cycle.
  assign in_ready   = !rst && (r_state == IDLE || r_state == WRITE);
  assign mem_rready = !rst && (r_state == WAIT_MEM);
  assign w_accept   = in_valid && in_ready;
  assign w_mem_fire = mem_rvalid && mem_rready;

  ysyx_23060201_load_ext #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_ext (
    .rdata    (mem_rdata),
    .fmt      (r_fmt),
    .addr_lo  (r_addr_lo),
    .data     (w_ext_data),
    .misalign (w_misalign),
    .bad_fmt  (w_bad_fmt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = in_is_load ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        if (w_mem_fire) w_state_nxt = WRITE;
      end
      WRITE: begin
        if (w_accept) w_state_nxt = in_is_load ? WAIT_MEM : WRITE;
        else          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: packet registers are cleared on reset even though the state
      // machine alone would hide them, so outputs never show stale data.
      r_state   <= IDLE;
      r_rd      <= '0;
      r_rd_wen  <= 1'b0;
      r_fmt     <= 3'b000;
      r_addr_lo <= 2'b00;
      r_data    <= '0;
      r_pc      <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rd      <= in_rd;
        r_rd_wen  <= in_rd_wen;
        r_fmt     <= in_load_fmt;
        r_addr_lo <= in_addr_lo;
        r_pc      <= in_pc;
        // For loads r_data is overwritten when the read data arrives.
        r_data    <= in_result;
        r_err     <= 1'b0;
      end else if (w_mem_fire) begin
        r_data <= w_ext_data;
        r_err  <= (mem_rresp != RESP_OKAY) | w_misalign | w_bad_fmt;
      end
    end
  end

  // All writeback outputs are decoded from registered state only. The rst
  // term forces them low during the first reset cycle, before the state
  // register has been cleared.
  assign w_in_write = !rst && (r_state == WRITE);
  assign wb_valid   = w_in_write;
  assign wb_pc      = w_in_write ? r_pc : '0;
  assign wb_err     = w_in_write && r_err;
  assign gpr_wen    = w_in_write && r_rd_wen && (r_rd != '0) && !r_err;
  assign gpr_waddr  = w_in_write ? r_rd : '0;
  assign gpr_wdata  = w_in_write ? r_data : '0;

endmodule

// File: tb/tb_ysyx_23060201_wbu.sv
// Directed, self-checking bench for ysyx_23060201_wbu.
// Expected commits are pushed into a scoreboard when the stimulus that
// causes them is driven (packet for non-loads, read data for loads), and a
// negedge monitor pops and compares them whenever wb_valid is seen.
module tb_ysyx_23060201_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_load_fmt;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic [31:0] in_pc;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_err;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_23060201_wbu #(
    .GPR_ADDR_WIDTH (5),
    .DATA_WIDTH     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_rd_wen   (in_rd_wen),
    .in_is_load  (in_is_load),
    .in_load_fmt (in_load_fmt),
    .in_addr_lo  (in_addr_lo),
    .in_result   (in_result),
    .in_pc       (in_pc),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .gpr_wen     (gpr_wen),
    .gpr_waddr   (gpr_waddr),
    .gpr_wdata   (gpr_wdata),
    .wb_valid    (wb_valid),
    .wb_pc       (wb_pc),
    .wb_err      (wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] rd, input logic rd_wen, input logic is_load,
                     input logic [2:0] fmt, input logic [1:0] lo,
                     input logic [31:0] result, input logic [31:0] pc);
    in_valid    = 1'b1;
    in_rd       = rd;
    in_rd_wen   = rd_wen;
    in_is_load  = is_load;
    in_load_fmt = fmt;
    in_addr_lo  = lo;
    in_result   = result;
    in_pc       = pc;
  endtask

  // The commit is due in the cycle after the one in which this is called.
  task automatic expect_commit(input logic wen, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic [31:0] pc,
                               input logic err);
    exp_t e;
    e.wen   = wen;
    e.waddr = waddr;
    e.wdata = wdata;
    e.pc    = pc;
    e.err   = err;
    e.cyc   = cyc + 1;
    sb.push_back(e);
  endtask

  // Load accepted in cycle N, read data returned in cycle N+4.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] fmt, input logic [1:0] lo,
                         input logic [31:0] rdata, input logic [1:0] resp,
                         input logic exp_wen, input logic [31:0] exp_data,
                         input logic exp_err, input logic [31:0] pc);
    step();
    put(rd, 1'b1, 1'b1, fmt, lo, 32'hBAD0_BAD0, pc);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("load_wait_rready", {31'b0, mem_rready}, 32'd1);
    check("load_wait_no_commit", {31'b0, wb_valid}, 32'd0);
    repeat (3) step();
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    mem_rresp  = resp;
    expect_commit(exp_wen, rd, exp_data, pc, exp_err);
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    mem_rresp  = 2'b00;
    step();
  endtask

  // Commit monitor
  always @(negedge clk) begin
    exp_t e;
    if (wb_valid === 1'b1) begin
      check("commit_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("commit_cycle", cyc, e.cyc);
        check("wb_pc", wb_pc, e.pc);
        check("wb_err", {31'b0, wb_err}, {31'b0, e.err});
        check("gpr_wen", {31'b0, gpr_wen}, {31'b0, e.wen});
        if (e.wen) begin
          check("gpr_waddr", {27'b0, gpr_waddr}, {27'b0, e.waddr});
          check("gpr_wdata", gpr_wdata, e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    mem_rresp  = 2'b00;
    put(5'd3, 1'b1, 1'b0, 3'b000, 2'b00, 32'hDEAD_BEEF, 32'h0000_0100);

    // Reset held 3 cycles with in_valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_gpr_wen", {31'b0, gpr_wen}, 32'd0);
      check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      check("rst_mem_rready", {31'b0, mem_rready}, 32'd0);
    end
    check("rst_gpr_waddr", {27'b0, gpr_waddr}, 32'd0);
    check("rst_gpr_wdata", gpr_wdata, 32'd0);
    check("rst_wb_pc", wb_pc, 32'd0);
    check("rst_wb_err", {31'b0, wb_err}, 32'd0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // ALU burst: x5=0x11, x6=0x22, then rd=0 (commit without write)
    step();
    put(5'd5, 1'b1, 1'b0, 3'b000, 2'b00, 32'h11, 32'h0000_1000);
    expect_commit(1'b1, 5'd5, 32'h11, 32'h0000_1000, 1'b0);
    @(negedge clk);
    check("burst_ready_0", {31'b0, in_ready}, 32'd1);
    step();
    put(5'd6, 1'b1, 1'b0, 3'b000, 2'b00, 32'h22, 32'h0000_1004);
    expect_commit(1'b1, 5'd6, 32'h22, 32'h0000_1004, 1'b0);
    @(negedge clk);
    check("burst_ready_1", {31'b0, in_ready}, 32'd1);
    step();
    put(5'd0, 1'b1, 1'b0, 3'b000, 2'b00, 32'h33, 32'h0000_1008);
    expect_commit(1'b0, 5'd0, 32'h33, 32'h0000_1008, 1'b0);
    @(negedge clk);
    check("burst_ready_2", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("burst_ready_3", {31'b0, in_ready}, 32'd1);
    step();

    // Loads on 0x80F0_7F81
    do_load(5'd10, 3'b000, 2'd0, 32'h80F0_7F81, 2'b00, 1'b1, 32'hFFFF_FF81, 1'b0, 32'h0000_2000);
    do_load(5'd11, 3'b100, 2'd1, 32'h80F0_7F81, 2'b00, 1'b1, 32'h0000_007F, 1'b0, 32'h0000_2004);
    do_load(5'd12, 3'b001, 2'd2, 32'h80F0_7F81, 2'b00, 1'b1, 32'hFFFF_80F0, 1'b0, 32'h0000_2008);
    do_load(5'd13, 3'b010, 2'd0, 32'h80F0_7F81, 2'b00, 1'b1, 32'h80F0_7F81, 1'b0, 32'h0000_200C);
    do_load(5'd14, 3'b101, 2'd0, 32'h80F0_7F81, 2'b00, 1'b1, 32'h0000_7F81, 1'b0, 32'h0000_2010);
    do_load(5'd15, 3'b100, 2'd3, 32'h80F0_7F81, 2'b00, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_2014);

    // Load errors: misaligned LW, error response, bad funct3
    do_load(5'd16, 3'b010, 2'd2, 32'h80F0_7F81, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_2018);
    do_load(5'd17, 3'b000, 2'd0, 32'h80F0_7F81, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0000_201C);
    do_load(5'd18, 3'b011, 2'd0, 32'h80F0_7F81, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_2020);

    // Reset in the middle of a load abandons it
    step();
    put(5'd19, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'h0000_3000);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_mem_rready", {31'b0, mem_rready}, 32'd0);
    check("midrst_gpr_wen", {31'b0, gpr_wen}, 32'd0);
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    check("midrst_idle_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_idle_rready", {31'b0, mem_rready}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    @(negedge clk);
    check("midrst_no_commit", {31'b0, wb_valid}, 32'd0);
    check("midrst_no_wen", {31'b0, gpr_wen}, 32'd0);
    step();

    // Backpressure: packet held during WAIT_MEM, accepted in WRITE
    step();
    put(5'd20, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'h0000_4000);
    step();
    put(5'd21, 1'b1, 1'b0, 3'b000, 2'd0, 32'h5555_AAAA, 32'h0000_4004);
    @(negedge clk);
    check("bp_ready_low_0", {31'b0, in_ready}, 32'd0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    mem_rresp  = 2'b00;
    expect_commit(1'b1, 5'd20, 32'h1234_5678, 32'h0000_4000, 1'b0);
    @(negedge clk);
    check("bp_ready_low_1", {31'b0, in_ready}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    expect_commit(1'b1, 5'd21, 32'h5555_AAAA, 32'h0000_4004, 1'b0);
    @(negedge clk);
    check("bp_ready_in_write", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    repeat (3) step();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
